cyclic_fifo: RTL and testbench

CYCLIC_FIFO -- requirements
Module: cyclic_fifo

---
 rtl/cyclic_fifo.sv | 97 +++++++++
 tb/tb_cyclic_fifo.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/cyclic_fifo.sv
// Circular-buffer FIFO of 2**ADDR words; read data is registered and valid one cycle after an accepted read.
// No stall: writes while full are dropped (fifo_of pulse), reads while empty are dropped (fifo_uf pulse).
module cyclic_fifo #(
    parameter int DATA = 8,
    parameter int ADDR = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DATA-1:0] write_data,
    input  logic            write_req,
    input  logic            read_req,
    output logic [DATA-1:0] read_data,
    output logic            read_data_valid,
    output logic            fifo_empty,
    output logic            fifo_full,
    output logic            fifo_of,
    output logic            fifo_uf
);

    localparam int DEPTH = 2 ** ADDR;
    localparam logic [ADDR:0] FULL_CNT = (ADDR + 1)'(DEPTH);

    logic [DATA-1:0] mem_q [DEPTH];

    logic [ADDR-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR:0]   count_q, count_d;
    logic [DATA-1:0] rd_data_q, rd_data_d;
    logic            rd_vld_q, rd_vld_d;
    logic            of_q, of_d;
    logic            uf_q, uf_d;
    logic            rd_acc, wr_acc;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);

    // A read on the same edge frees a slot, so a full FIFO can still accept the write.
    assign rd_acc = read_req && !fifo_empty;
    assign wr_acc = write_req && (!fifo_full || rd_acc);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;
        rd_vld_d  = rd_acc;
        of_d      = write_req && !wr_acc;
        uf_d      = read_req && !rd_acc;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR'(1);
        end
        if (rd_acc) begin
            rd_ptr_d  = rd_ptr_q + ADDR'(1);
            rd_data_d = mem_q[rd_ptr_q];
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + (ADDR + 1)'(1);
            2'b01:   count_d = count_q - (ADDR + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
            rd_vld_q  <= 1'b0;
            of_q      <= 1'b0;
            uf_q      <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
            rd_vld_q  <= rd_vld_d;
            of_q      <= of_d;
            uf_q      <= uf_d;
        end
    end

    // Storage is left unreset; stale words are unreachable once the pointers and count clear.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= write_data;
        end
    end

    assign read_data       = rd_data_q;
    assign read_data_valid = rd_vld_q;
    assign fifo_of         = of_q;
    assign fifo_uf         = uf_q;

endmodule

// File: tb/tb_cyclic_fifo.sv
// Directed bench for cyclic_fifo: a reference queue models occupancy, and dequeued words are
// checked through an expected-read scoreboard.
module tb_cyclic_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] write_data;
    logic       write_req;
    logic       read_req;
    logic [7:0] read_data;
    logic       read_data_valid;
    logic       fifo_empty;
    logic       fifo_full;
    logic       fifo_of;
    logic       fifo_uf;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_q [$];
    logic [7:0] sb_q [$];

    cyclic_fifo #(.DATA(8), .ADDR(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .write_data      (write_data),
        .write_req       (write_req),
        .read_req        (read_req),
        .read_data       (read_data),
        .read_data_valid (read_data_valid),
        .fifo_empty      (fifo_empty),
        .fifo_full       (fifo_full),
        .fifo_of         (fifo_of),
        .fifo_uf         (fifo_uf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; called just after a rising edge, checks #1 after the next one.
    task automatic cycle(input string tag, input logic w, input logic r, input logic [7:0] d);
        bit exp_rd;
        bit exp_wr;
        logic [7:0] exp_word;
        exp_rd = r && (model_q.size() > 0);
        exp_wr = w && ((model_q.size() < 16) || exp_rd);
        write_req  = w;
        read_req   = r;
        write_data = d;
        if (exp_rd) sb_q.push_back(model_q.pop_front());
        if (exp_wr) model_q.push_back(d);
        @(posedge clk);
        #1;
        write_req = 1'b0;
        read_req  = 1'b0;
        chk({tag, ".valid"}, 32'(read_data_valid), 32'(exp_rd));
        if (exp_rd) begin
            exp_word = sb_q.pop_front();
            chk({tag, ".data"}, 32'(read_data), 32'(exp_word));
        end
        chk({tag, ".of"},    32'(fifo_of),    32'(w && !exp_wr));
        chk({tag, ".uf"},    32'(fifo_uf),    32'(r && !exp_rd));
        chk({tag, ".full"},  32'(fifo_full),  32'(model_q.size() == 16));
        chk({tag, ".empty"}, 32'(fifo_empty), 32'(model_q.size() == 0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        write_req  = 1'b0;
        read_req   = 1'b0;
        write_data = 8'h00;

        // Reset held through one rising edge, then released between edges.
        #3;
        chk("rst_async.empty", 32'(fifo_empty), 32'd1);
        chk("rst_async.full",  32'(fifo_full),  32'd0);
        @(posedge clk);
        #1;
        chk("rst.empty", 32'(fifo_empty),      32'd1);
        chk("rst.full",  32'(fifo_full),       32'd0);
        chk("rst.data",  32'(read_data),       32'd0);
        chk("rst.valid", 32'(read_data_valid), 32'd0);
        chk("rst.of",    32'(fifo_of),         32'd0);
        chk("rst.uf",    32'(fifo_uf),         32'd0);
        #2 rst = 1'b1;
        cycle("idle0", 1'b0, 1'b0, 8'h00);

        // Fill beyond capacity: writes 17 and 18 overflow.
        for (int i = 1; i <= 18; i++) cycle("fill", 1'b1, 1'b0, 8'(i));
        chk("fill.depth", 32'(model_q.size()), 32'd16);
        cycle("idle1", 1'b0, 1'b0, 8'h00);

        // Drain beyond empty: reads 17..20 underflow on consecutive cycles.
        for (int i = 1; i <= 20; i++) cycle("drain", 1'b0, 1'b1, 8'h00);
        cycle("idle2", 1'b0, 1'b0, 8'h00);

        // Wrap-around of both pointers.
        for (int i = 0; i < 10; i++) cycle("wrap_w10", 1'b1, 1'b0, 8'(8'h20 + i));
        for (int i = 0; i < 10; i++) cycle("wrap_r10", 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 12; i++) cycle("wrap_w12", 1'b1, 1'b0, 8'(8'h30 + i));
        for (int i = 0; i < 12; i++) cycle("wrap_r12", 1'b0, 1'b1, 8'h00);

        // Simultaneous read/write at full, then at empty.
        for (int i = 0; i < 16; i++) cycle("sim_fill", 1'b1, 1'b0, 8'(8'h40 + i));
        cycle("sim_full_rw", 1'b1, 1'b1, 8'hAA);
        for (int i = 0; i < 16; i++) cycle("sim_drain", 1'b0, 1'b1, 8'h00);
        cycle("sim_empty_rw", 1'b1, 1'b1, 8'h55);
        cycle("sim_read55", 1'b0, 1'b1, 8'h00);
        cycle("idle3", 1'b0, 1'b0, 8'h00);

        // Mid-operation reset asserted between edges while read_data_valid is high.
        for (int i = 0; i < 5; i++) cycle("mid_w", 1'b1, 1'b0, 8'(8'h60 + i));
        cycle("mid_r", 1'b0, 1'b1, 8'h00);
        #1 rst = 1'b0;
        #1;
        chk("midrst.empty", 32'(fifo_empty),      32'd1);
        chk("midrst.full",  32'(fifo_full),       32'd0);
        chk("midrst.valid", 32'(read_data_valid), 32'd0);
        chk("midrst.data",  32'(read_data),       32'd0);
        model_q.delete();
        sb_q.delete();
        #10 rst = 1'b1;
        cycle("post_w", 1'b1, 1'b0, 8'h77);
        cycle("post_r", 1'b0, 1'b1, 8'h00);
        cycle("post_idle", 1'b0, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
